// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter:
// FSM state encoding, default sizing constants and a wrap-around index helper.
package mult_share_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_BIT_WIDTH   = 8;
   localparam int DEF_MUL_TIMEOUT = 31;

   // Valid only for base < n and off < n, which is all the arbiter ever asks.
   function automatic int unsigned wrap_add(int unsigned base, int unsigned off, int unsigned n);
      int unsigned s;
      s = base + off;
      return (s >= n) ? s - n : s;
   endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Lane-side request/response handshakes plus the shared-multiplier port,
// bundled so the arbiter and its environment connect through one interface.
interface mult_share_arbiter_if
   import mult_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int BIT_WIDTH = DEF_BIT_WIDTH
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ*BIT_WIDTH-1:0] req_a;
   logic [NUM_REQ*BIT_WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]           rsp_valid;
   logic [NUM_REQ-1:0]           rsp_ready;
   logic [2*BIT_WIDTH-1:0]       rsp_data;
   logic                         mul_start;
   logic [BIT_WIDTH-1:0]         mul_a;
   logic [BIT_WIDTH-1:0]         mul_b;
   logic                         mul_done;
   logic [2*BIT_WIDTH-1:0]       mul_result;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
      output req_ready, rsp_valid, rsp_data, mul_start, mul_a, mul_b
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
      input  req_ready, rsp_valid, rsp_data, mul_start, mul_a, mul_b
   );

endinterface

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid lane at or above rr_ptr, with wrap.
// Produces the winner as both an index and a one-hot vector.
module mult_share_arbiter_rr_pick
   import mult_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any
);

   logic [IDX_W-1:0]   cand [NUM_REQ];
   logic [NUM_REQ-1:0] valid_rot;

   assign any = |req_valid;

   // cand[k] is the lane at priority k for the current pointer.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         assign cand[gi]      = IDX_W'(wrap_add(32'(rr_ptr), gi, NUM_REQ));
         assign valid_rot[gi] = req_valid[cand[gi]];
         assign gnt[gi]       = any && (gnt_idx == IDX_W'(gi));
      end
   endgenerate

   // Scan lowest priority first so the highest-priority hit is the last write.
   always_comb begin
      gnt_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (valid_rot[k]) gnt_idx = cand[k];
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential multiplier between NUM_REQ lanes: round-robin accept,
// operand latch, start pulse, watchdog-guarded wait, then a per-lane response.
module mult_share_arbiter
   import mult_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
   parameter int MUL_TIMEOUT = DEF_MUL_TIMEOUT
)(
   input  logic                 clk,
   input  logic                 rst_n,
   mult_share_arbiter_if.slave  bus,
   output logic                 busy,
   output logic                 err_timeout
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(MUL_TIMEOUT + 1);
   // Last WAIT cycle the watchdog tolerates: MUL_TIMEOUT WAIT cycles in total.
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MUL_TIMEOUT - 1);

   state_t                  state_reg, state_next;
   logic [IDX_W-1:0]        rr_ptr_reg;
   logic [IDX_W-1:0]        owner_reg;
   logic [WD_W-1:0]         wdog_reg;
   logic [BIT_WIDTH-1:0]    mul_a_reg, mul_b_reg;
   logic [2*BIT_WIDTH-1:0]  rsp_data_reg;
   logic                    err_reg;

   logic [NUM_REQ-1:0]      pick_gnt;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_any;
   logic                    accept, capture_done, wdog_fire;

   logic [BIT_WIDTH-1:0]    lane_a [NUM_REQ];
   logic [BIT_WIDTH-1:0]    lane_b [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign lane_a[gi] = bus.req_a[gi*BIT_WIDTH +: BIT_WIDTH];
         assign lane_b[gi] = bus.req_b[gi*BIT_WIDTH +: BIT_WIDTH];
         assign bus.rsp_valid[gi] = (state_reg == ST_RESP) && (owner_reg == IDX_W'(gi));
      end
   endgenerate

   mult_share_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_valid (bus.req_valid),
      .rr_ptr    (rr_ptr_reg),
      .gnt       (pick_gnt),
      .gnt_idx   (pick_idx),
      .any       (pick_any)
   );

   always_comb begin
      state_next   = state_reg;
      accept       = 1'b0;
      capture_done = 1'b0;
      wdog_fire    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (pick_any) begin
               accept     = 1'b1;
               state_next = ST_START;
            end
         end
         ST_START: state_next = ST_WAIT;
         ST_WAIT: begin
            // A result arriving on the watchdog's last cycle still counts.
            if (bus.mul_done) begin
               capture_done = 1'b1;
               state_next   = ST_RESP;
            end else if (wdog_reg == WD_LAST) begin
               wdog_fire  = 1'b1;
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready[owner_reg]) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         rr_ptr_reg   <= '0;
         owner_reg    <= '0;
         wdog_reg     <= '0;
         mul_a_reg    <= '0;
         mul_b_reg    <= '0;
         rsp_data_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            owner_reg  <= pick_idx;
            mul_a_reg  <= lane_a[pick_idx];
            mul_b_reg  <= lane_b[pick_idx];
            rr_ptr_reg <= IDX_W'(wrap_add(32'(pick_idx), 1, NUM_REQ));
         end
         if (state_reg == ST_START) begin
            wdog_reg <= '0;
         end else if (state_reg == ST_WAIT && !bus.mul_done) begin
            wdog_reg <= wdog_reg + 1'b1;
         end
         if (capture_done) begin
            rsp_data_reg <= bus.mul_result;
         end else if (wdog_fire) begin
            rsp_data_reg <= '0;
            err_reg      <= 1'b1;
         end
      end
   end

   // Gated by rst_n so no accept is offered while reset is held.
   assign bus.req_ready = (state_reg == ST_IDLE && rst_n) ? pick_gnt : '0;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.mul_start = (state_reg == ST_START);
   assign bus.mul_a     = mul_a_reg;
   assign bus.mul_b     = mul_b_reg;
   assign busy          = (state_reg != ST_IDLE);
   assign err_timeout   = err_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural multiplier and
// a round-robin reference model; one line per transaction.
module tb_mult_share_arbiter;

   localparam int N   = 4;
   localparam int BW  = 8;
   localparam int TMO = 31;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy, err_timeout;

   mult_share_arbiter_if #(.NUM_REQ(N), .BIT_WIDTH(BW)) bus();

   mult_share_arbiter #(
      .NUM_REQ     (N),
      .BIT_WIDTH   (BW),
      .MUL_TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int exp_ptr = 0;
   int mul_lat = 9;
   bit model_hang = 1'b0;
   logic [BW-1:0] op_a [N];
   logic [BW-1:0] op_b [N];

   function automatic logic [15:0] prod16(logic [7:0] a, logic [7:0] b);
      int x, y;
      x = int'($signed(a));
      y = int'($signed(b));
      return 16'(x * y);
   endfunction

   // Reference arbitration: first valid lane searching upward from ptr.
   function automatic int model_pick(logic [N-1:0] mask, int ptr);
      for (int k = 0; k < N; k++) begin
         if (mask[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(logic [N-1:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Behavioural multiplier: done one cycle, mul_lat cycles after start.
   initial begin
      int rem;
      logic [BW-1:0] ca, cb;
      rem = 0;
      ca = '0;
      cb = '0;
      bus.mul_done = 1'b0;
      bus.mul_result = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            rem = 0;
            bus.mul_done = 1'b0;
            bus.mul_result = '0;
         end else if (bus.mul_start) begin
            ca = bus.mul_a;
            cb = bus.mul_b;
            rem = model_hang ? 0 : mul_lat;
            bus.mul_done = 1'b0;
            bus.mul_result = 16'($urandom);
         end else if (rem > 0) begin
            rem--;
            bus.mul_done = (rem == 0);
            bus.mul_result = (rem == 0) ? prod16(ca, cb) : 16'($urandom);
         end else begin
            bus.mul_done = 1'b0;
            bus.mul_result = 16'($urandom);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops;
      for (int i = 0; i < N; i++) begin
         op_a[i] = 8'($urandom);
         op_b[i] = 8'($urandom);
         bus.req_a[i*BW +: BW] = op_a[i];
         bus.req_b[i*BW +: BW] = op_b[i];
      end
   endtask

   task automatic wait_req(output int lane, output int n, output bit ok);
      n = 0;
      ok = 1'b0;
      lane = -1;
      #1;
      while (!ok && n < 100) begin
         if (|(bus.req_ready & bus.req_valid)) begin
            lane = onehot_idx(bus.req_ready);
            ok = 1'b1;
         end else begin
            tick;
            n++;
         end
      end
   endtask

   task automatic wait_rsp(output int lane, output int n, output bit ok);
      n = 0;
      ok = 1'b0;
      lane = -1;
      #1;
      while (!ok && n < 100) begin
         if (|bus.rsp_valid) begin
            lane = onehot_idx(bus.rsp_valid);
            ok = 1'b1;
         end else begin
            tick;
            n++;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.req_valid = '1;
      bus.rsp_ready = '1;
      rand_ops;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0) begin
         errors++;
         $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, expected 0000/0000", bus.req_ready, bus.rsp_valid);
      end
      checks++;
      if (bus.rsp_data !== 16'h0 || bus.mul_start !== 1'b0 || bus.mul_a !== 8'h0 || bus.mul_b !== 8'h0) begin
         errors++;
         $display("FAIL reset_datapath: rsp_data=%h mul_start=%b mul_a=%h mul_b=%h, expected all 0",
                  bus.rsp_data, bus.mul_start, bus.mul_a, bus.mul_b);
      end
      checks++;
      if (busy !== 1'b0 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: busy=%b err_timeout=%b, expected 0/0", busy, err_timeout);
      end
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      rst_n = 1'b1;
      exp_ptr = 0;
      tick;
      $display("reset: released, busy=%b", busy);
   endtask

   task automatic test_round_robin;
      logic [N-1:0] masks [2];
      int counts [2];
      int lane, n, exp_lane, rlane;
      bit ok;
      logic [15:0] exp_data;
      masks[0] = 4'b1111; counts[0] = 5;
      masks[1] = 4'b1010; counts[1] = 3;
      for (int s = 0; s < 2; s++) begin
         bus.req_valid = masks[s];
         for (int j = 0; j < counts[s]; j++) begin
            rand_ops;
            wait_req(lane, n, ok);
            exp_lane = model_pick(masks[s], exp_ptr);
            checks++;
            if (!ok || lane != exp_lane) begin
               errors++;
               $display("FAIL rr_grant: mask=%b got lane %0d, expected lane %0d", masks[s], lane, exp_lane);
            end
            exp_data = prod16(op_a[exp_lane], op_b[exp_lane]);
            exp_ptr = (exp_lane + 1) % N;
            tick;
            rand_ops;
            wait_rsp(rlane, n, ok);
            checks++;
            if (!ok || rlane != exp_lane || bus.rsp_data !== exp_data) begin
               errors++;
               $display("FAIL rr_response: lane %0d data %h, expected lane %0d data %h",
                        rlane, bus.rsp_data, exp_lane, exp_data);
            end
            $display("rr: mask=%b grant=%0d rsp_data=%h", masks[s], lane, bus.rsp_data);
            bus.rsp_ready = 4'(1 << exp_lane);
            tick;
            bus.rsp_ready = '0;
         end
      end
      bus.req_valid = '0;
   endtask

   task automatic test_single;
      int lane, n;
      bit ok;
      mul_lat = 9;
      op_a[0] = 8'd3;
      op_b[0] = 8'd5;
      bus.req_a[7:0] = op_a[0];
      bus.req_b[7:0] = op_b[0];
      bus.req_valid = 4'b0001;
      wait_req(lane, n, ok);
      checks++;
      if (!ok || bus.req_ready !== 4'(1 << model_pick(4'b0001, exp_ptr))) begin
         errors++;
         $display("FAIL single_accept: req_ready=%b, expected 0001", bus.req_ready);
      end
      exp_ptr = 1;
      tick;
      bus.req_valid = '0;
      checks++;
      if (bus.mul_start !== 1'b1 || bus.mul_a !== 8'd3 || bus.mul_b !== 8'd5) begin
         errors++;
         $display("FAIL single_start: mul_start=%b a=%h b=%h, expected 1/03/05", bus.mul_start, bus.mul_a, bus.mul_b);
      end
      tick;
      checks++;
      if (bus.mul_start !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse: mul_start=%b one cycle after start, expected 0", bus.mul_start);
      end
      wait_rsp(lane, n, ok);
      checks++;
      if (!ok || n != mul_lat || bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 16'd15) begin
         errors++;
         $display("FAIL single_rsp: wait=%0d rsp_valid=%b data=%h, expected wait=%0d 0001 000f",
                  n, bus.rsp_valid, bus.rsp_data, mul_lat);
      end
      $display("single: lane 0 3*5 -> %h after %0d cycles", bus.rsp_data, n);
      bus.rsp_ready = 4'b0001;
      tick;
      bus.rsp_ready = '0;
      checks++;
      if (busy !== 1'b0 || bus.rsp_valid !== 4'b0) begin
         errors++;
         $display("FAIL single_idle: busy=%b rsp_valid=%b, expected 0/0000", busy, bus.rsp_valid);
      end
   endtask

   task automatic test_signed;
      int lane, n, bad;
      bit ok;
      rand_ops;
      op_a[2] = 8'hFD;
      op_b[2] = 8'h07;
      bus.req_a[23:16] = op_a[2];
      bus.req_b[23:16] = op_b[2];
      bus.req_valid = 4'b0100;
      wait_req(lane, n, ok);
      checks++;
      if (!ok || lane != model_pick(4'b0100, exp_ptr)) begin
         errors++;
         $display("FAIL signed_accept: lane %0d, expected 2", lane);
      end
      exp_ptr = 3;
      tick;
      bus.req_valid = '0;
      rand_ops;
      bad = 0;
      n = 0;
      while (bus.rsp_valid === 4'b0 && n < 100) begin
         if (bus.mul_a !== 8'hFD || bus.mul_b !== 8'h07) bad++;
         tick;
         n++;
      end
      checks++;
      if (bad != 0 || n != mul_lat + 1) begin
         errors++;
         $display("FAIL signed_stable: %0d unstable cycles, wait=%0d, expected 0 and %0d", bad, n, mul_lat + 1);
      end
      checks++;
      if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 16'hFFEB) begin
         errors++;
         $display("FAIL signed_rsp: rsp_valid=%b data=%h, expected 0100 ffeb", bus.rsp_valid, bus.rsp_data);
      end
      $display("signed: lane 2 -3*7 -> %h", bus.rsp_data);
      bus.rsp_ready = 4'b0100;
      tick;
      bus.rsp_ready = '0;
   endtask

   task automatic test_hold;
      int lane, n;
      bit ok;
      logic [15:0] exp_data;
      rand_ops;
      bus.req_valid = 4'b0100;
      wait_req(lane, n, ok);
      checks++;
      if (!ok || lane != model_pick(4'b0100, exp_ptr)) begin
         errors++;
         $display("FAIL hold_accept: lane %0d, expected 2", lane);
      end
      exp_ptr = 3;
      exp_data = prod16(op_a[2], op_b[2]);
      tick;
      bus.req_valid = 4'b1111;
      wait_rsp(lane, n, ok);
      bus.rsp_ready = 4'b1011;
      for (int c = 0; c < 5; c++) begin
         tick;
         checks++;
         if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== exp_data || bus.req_ready !== 4'b0 || bus.mul_start !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: rsp_valid=%b data=%h req_ready=%b mul_start=%b, expected 0100 %h 0000 0",
                     c, bus.rsp_valid, bus.rsp_data, bus.req_ready, bus.mul_start, exp_data);
         end
      end
      bus.rsp_ready = 4'b0100;
      tick;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      #1;
      checks++;
      if (busy !== 1'b0 || bus.rsp_valid !== 4'b0) begin
         errors++;
         $display("FAIL hold_release: busy=%b rsp_valid=%b, expected 0/0000", busy, bus.rsp_valid);
      end
      $display("hold: lane 2 held 5 cycles, data %h", exp_data);
   endtask

   task automatic test_back_to_back;
      int lane, n, exp_lane, rlane, n2;
      bit ok, ok2;
      logic [15:0] exp_data;
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 4'b1111;
      rand_ops;
      for (int k = 0; k < 4; k++) begin
         wait_req(lane, n, ok);
         exp_lane = model_pick(4'b1111, exp_ptr);
         checks++;
         if (!ok || lane != exp_lane || (k > 0 && n != 0)) begin
            errors++;
            $display("FAIL b2b_accept%0d: lane %0d gap %0d, expected lane %0d gap 0", k, lane, n, exp_lane);
         end
         exp_data = prod16(op_a[exp_lane], op_b[exp_lane]);
         exp_ptr = (exp_lane + 1) % N;
         tick;
         if (k == 3) bus.req_valid = '0;
         rand_ops;
         wait_rsp(rlane, n2, ok2);
         checks++;
         if (!ok2 || rlane != exp_lane || bus.rsp_data !== exp_data || n2 != mul_lat + 1) begin
            errors++;
            $display("FAIL b2b_rsp%0d: lane %0d data %h wait %0d, expected lane %0d data %h wait %0d",
                     k, rlane, bus.rsp_data, n2, exp_lane, exp_data, mul_lat + 1);
         end
         $display("b2b: grant=%0d rsp_data=%h", lane, bus.rsp_data);
         tick;
      end
      bus.rsp_ready = '0;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_done_at_timeout;
      int lane, n;
      bit ok;
      logic [15:0] exp_data;
      mul_lat = TMO;
      rand_ops;
      bus.req_valid = 4'b0010;
      wait_req(lane, n, ok);
      exp_ptr = 2;
      exp_data = prod16(op_a[1], op_b[1]);
      tick;
      bus.req_valid = '0;
      wait_rsp(lane, n, ok);
      checks++;
      if (!ok || lane != 1 || n != TMO + 1 || bus.rsp_data !== exp_data || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL done_at_timeout: lane %0d wait %0d data %h err %b, expected 1 %0d %h 0",
                  lane, n, bus.rsp_data, err_timeout, TMO + 1, exp_data);
      end
      $display("edge: done on last watchdog cycle, data %h err=%b", bus.rsp_data, err_timeout);
      bus.rsp_ready = 4'b0010;
      tick;
      bus.rsp_ready = '0;
      mul_lat = 9;
   endtask

   task automatic test_timeout;
      int lane, n;
      bit ok;
      logic [15:0] exp_data;
      model_hang = 1'b1;
      rand_ops;
      bus.req_valid = 4'b0001;
      wait_req(lane, n, ok);
      exp_ptr = 1;
      tick;
      bus.req_valid = '0;
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pre: err_timeout=%b at start, expected 0", err_timeout);
      end
      wait_rsp(lane, n, ok);
      checks++;
      if (!ok || n != TMO + 1 || bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 16'h0 || err_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_fire: wait %0d rsp_valid=%b data %h err %b, expected %0d 0001 0000 1",
                  n, bus.rsp_valid, bus.rsp_data, err_timeout, TMO + 1);
      end
      $display("timeout: RESP after %0d cycles, err=%b", n + 1, err_timeout);
      bus.rsp_ready = 4'b0001;
      tick;
      bus.rsp_ready = '0;
      model_hang = 1'b0;
      rand_ops;
      bus.req_valid = 4'b1000;
      wait_req(lane, n, ok);
      exp_ptr = 0;
      exp_data = prod16(op_a[3], op_b[3]);
      tick;
      bus.req_valid = '0;
      wait_rsp(lane, n, ok);
      checks++;
      if (!ok || lane != 3 || bus.rsp_data !== exp_data || err_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: lane %0d data %h err %b, expected 3 %h 1", lane, bus.rsp_data, err_timeout, exp_data);
      end
      $display("timeout: later op lane 3 data %h err=%b", bus.rsp_data, err_timeout);
      bus.rsp_ready = 4'b1000;
      tick;
      bus.rsp_ready = '0;
   endtask

   task automatic test_async_reset;
      int lane, n, exp_lane;
      bit ok;
      logic [15:0] exp_data;
      rand_ops;
      op_a[1] = 8'h5A;
      op_b[1] = 8'hC3;
      bus.req_a[15:8] = op_a[1];
      bus.req_b[15:8] = op_b[1];
      bus.req_valid = 4'b0010;
      wait_req(lane, n, ok);
      tick;
      bus.req_valid = 4'b1111;
      repeat (3) tick;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0 || bus.mul_start !== 1'b0 ||
          bus.mul_a !== 8'h0 || bus.mul_b !== 8'h0 || bus.rsp_data !== 16'h0) begin
         errors++;
         $display("FAIL async_reset_bus: req_ready=%b rsp_valid=%b start=%b a=%h b=%h data=%h, expected all 0",
                  bus.req_ready, bus.rsp_valid, bus.mul_start, bus.mul_a, bus.mul_b, bus.rsp_data);
      end
      checks++;
      if (busy !== 1'b0 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_status: busy=%b err_timeout=%b, expected 0/0", busy, err_timeout);
      end
      tick;
      tick;
      rst_n = 1'b1;
      exp_ptr = 0;
      rand_ops;
      wait_req(lane, n, ok);
      exp_lane = model_pick(4'b1111, exp_ptr);
      checks++;
      if (!ok || lane != exp_lane) begin
         errors++;
         $display("FAIL async_reset_grant: lane %0d, expected lane %0d", lane, exp_lane);
      end
      exp_data = prod16(op_a[exp_lane], op_b[exp_lane]);
      exp_ptr = (exp_lane + 1) % N;
      tick;
      bus.req_valid = '0;
      wait_rsp(lane, n, ok);
      checks++;
      if (!ok || lane != exp_lane || bus.rsp_data !== exp_data) begin
         errors++;
         $display("FAIL async_reset_rsp: lane %0d data %h, expected lane %0d data %h", lane, bus.rsp_data, exp_lane, exp_data);
      end
      $display("async reset: first grant after release lane %0d data %h", exp_lane, bus.rsp_data);
      bus.rsp_ready = 4'(1 << exp_lane);
      tick;
      bus.rsp_ready = '0;
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_single;
      test_signed;
      test_hold;
      test_back_to_back;
      test_done_at_timeout;
      test_timeout;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation still running at %0t, expected completion", $time);
      $fatal(1, "time limit");
   end

endmodule
